// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with internal 16x oversampling and a
// valid/ready byte interface. Everything runs on the rising edge of clk.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int OS_DIV   = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [3:0]       s_cnt;
    logic [2:0]       b_cnt;
    logic [7:0]       shreg;

    // Decoded per-state actions for the datapath.
    logic cnt_clr, s_clr, shift_en, load_byte, ferr_set;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge value of its source, independent of
        // statement order.
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (div == DIV_W'(OS_DIV - 1));

    // Oversample divider; parked at 0 in IDLE so ticks align to the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (state == S_IDLE || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state datapath controls.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        cnt_clr    = 1'b0;
        s_clr      = 1'b0;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (tick && s_cnt == 4'd7) begin
                    if (!rx_s) begin
                        state_next = S_DATA;
                        s_clr      = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && s_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (b_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && s_cnt == 4'd15) begin
                    if (rx_s) begin
                        load_byte  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sample and bit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= '0;
            b_cnt <= '0;
        end else if (cnt_clr) begin
            s_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (s_clr) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= s_cnt + 1'b1;
            end
            if (shift_en && b_cnt != 3'd7) begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end

    // Shift register, filled LSB first at mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg[b_cnt] <= rx_s;
        end
    end

    // Output byte, handshake, overrun and framing-error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (load_byte) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at OS_DIV = 10 (160 cycles/bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Scoreboard and monitor state.
    logic [7:0] exp_q[$];
    int         pres_count = 0;
    int         ferr_count = 0;
    int         rise_cyc = -1;
    int         fall_cyc = -1;
    int         ferr_cyc = -1;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rand_en = 1'b0;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every new byte presentation pops the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_hs || rx_data != prev_data)) begin
                pres_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", rx_data, cyc);
                end else begin
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (!rx_valid && prev_valid) fall_cyc = cyc;
            if (frame_err) begin
                ferr_count++;
                ferr_cyc = cyc;
            end
            prev_valid = rx_valid;
            prev_data  = rx_data;
            prev_hs    = rx_valid && rx_ready;
        end
    end

    // Random consumer used only in the randomized phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Sends one 8N1 frame; bit edges at start + k*per_x10/10 cycles.
    // stop_low > 0 holds the stop bit low that many cycles instead.
    task automatic send_frame(input logic [7:0] d, input int per_x10, input int stop_low,
                              input bit expect_ok, output int start_cyc);
        logic [9:0] bits;
        int         end_c;
        bits = {1'b1, d, 1'b0};
        if (expect_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 9 && stop_low > 0) begin
                rx    = 1'b0;
                end_c = start_cyc + (9 * per_x10) / 10 + stop_low;
            end else begin
                rx    = bits[k];
                end_c = start_cyc + ((k + 1) * per_x10) / 10;
            end
            while (cyc < end_c) begin
                @(posedge clk);
                #1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic wait_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n, p0, f0, fs;
        logic [7:0] b;

        // Reset values.
        idle(4);
        check("rst_valid", {31'h0, rx_valid}, 0);
        rst_n = 1'b1;
        check("rst_data", {24'h0, rx_data}, 0);
        check("rst_ferr", {31'h0, frame_err}, 0);
        check("rst_overrun", {31'h0, overrun}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        idle(20);

        // Basic byte, consumer always ready.
        rx_ready = 1'b1;
        p0 = pres_count;
        f0 = ferr_count;
        send_frame(8'h55, 1600, 0, 1'b1, s);
        check("basic_rise", rise_cyc, s + 1523);
        check("basic_fall", fall_cyc, s + 1524);
        check("basic_count", pres_count, p0 + 1);
        check("basic_ferr", ferr_count, f0);
        idle(50);

        // Back-to-back bytes with consumer stalled.
        rx_ready = 1'b0;
        send_frame(8'hA3, 1600, 0, 1'b1, s);
        check("b2b_valid1", {31'h0, rx_valid}, 1);
        check("b2b_data1", {24'h0, rx_data}, 8'hA3);
        check("b2b_ovr1", {31'h0, overrun}, 0);
        send_frame(8'h0F, 1600, 0, 1'b1, s);
        check("b2b_data2", {24'h0, rx_data}, 8'h0F);
        check("b2b_ovr2", {31'h0, overrun}, 1);
        check("b2b_valid2", {31'h0, rx_valid}, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("b2b_accept", {31'h0, rx_valid}, 0);
        idle(50);

        // Glitch rejection: 50-cycle low pulse.
        p0 = pres_count;
        f0 = ferr_count;
        @(posedge clk);
        #1;
        n  = cyc;
        rx = 1'b0;
        idle(50);
        rx = 1'b1;
        wait_neg(n + 82);
        check("glitch_busy_before", {31'h0, busy}, 1);
        wait_neg(n + 83);
        check("glitch_busy_after", {31'h0, busy}, 0);
        idle(200);
        check("glitch_valid", pres_count, p0);
        check("glitch_ferr", ferr_count, f0);

        // Framing error, then recovery.
        rx_ready = 1'b1;
        p0 = pres_count;
        f0 = ferr_count;
        send_frame(8'hC3, 1600, 320, 1'b0, s);
        check("ferr_cycle", ferr_cyc, s + 1523);
        check("ferr_pulses", ferr_count, f0 + 1);
        check("ferr_no_valid", pres_count, p0);
        idle(40);
        send_frame(8'h12, 1600, 0, 1'b1, s);
        idle(10);
        check("ferr_recover", pres_count, p0 + 1);

        // Reset during data bit 4 of 0xFF.
        rx_ready = 1'b0;
        fork
            send_frame(8'hFF, 1600, 0, 1'b0, s);
            begin
                idle(881);
                rst_n = 1'b0;
                idle(3);
                rst_n = 1'b1;
                check("mrst_valid", {31'h0, rx_valid}, 0);
                check("mrst_data", {24'h0, rx_data}, 0);
                check("mrst_overrun", {31'h0, overrun}, 0);
                check("mrst_busy", {31'h0, busy}, 0);
            end
        join
        check("mrst_idle_busy", {31'h0, busy}, 0);
        check("mrst_idle_valid", {31'h0, rx_valid}, 0);
        check("mrst_idle_ferr", {31'h0, frame_err}, 0);
        idle(30);
        p0 = pres_count;
        send_frame(8'h81, 1600, 0, 1'b1, s);
        check("mrst_next", pres_count, p0 + 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(30);

        // Accept of 0x11 coincides with the stop-sample edge of 0x22.
        send_frame(8'h11, 1600, 0, 1'b1, s);
        check("sim_pending", {31'h0, rx_valid}, 1);
        fork
            send_frame(8'h22, 1600, 0, 1'b1, s);
            begin
                @(posedge clk);
                #2;
                fs = cyc;
                while (cyc < fs + 1522) begin
                    @(posedge clk);
                    #1;
                end
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
                check("sim_valid", {31'h0, rx_valid}, 1);
                check("sim_data", {24'h0, rx_data}, 8'h22);
                check("sim_overrun", {31'h0, overrun}, 0);
            end
        join
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("sim_drained", {31'h0, rx_valid}, 0);
        idle(20);

        // Randomized bytes with +/-3% baud error and a random consumer.
        p0 = pres_count;
        f0 = ferr_count;
        rand_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(1552, 1648), 0, 1'b1, s);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 100));
        end
        rand_en = 1'b0;
        rx_ready = 1'b1;
        idle(20);
        rx_ready = 1'b0;
        check("rand_count", pres_count, p0 + 24);
        check("rand_ferr", ferr_count, f0);
        check("rand_overrun", {31'h0, overrun}, 0);
        check("rand_q_empty", exp_q.size(), 0);
        check("rand_valid", {31'h0, rx_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
